// File: rtl/btn_ctrl_pkg.sv
// Shared constants for the button controller.
// Holds the default parameter values (SAMPLE_W, DB_DEPTH, LP_TICKS) and the
// speed encoding (SPEED_SLOW, SPEED_FAST) used by btn_ctrl.
package btn_ctrl_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned DB_DEPTH = 4;
  localparam int unsigned LP_TICKS = 64;

  localparam logic SPEED_SLOW = 1'b0;
  localparam logic SPEED_FAST = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: 2-flop synchroniser, DB_DEPTH-sample history
// taken on each prescaler tick, debounced level, and a one-cycle registered
// press pulse on a 0->1 change of the debounced level.
//
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   tick_i   shared sample tick (one cycle wide)
//   btn_i    raw asynchronous button
//   level_o  debounced level
//   press_o  one-cycle press pulse, the cycle after level_o rises
module btn_debounce #(
  parameter int unsigned DB_DEPTH = btn_ctrl_pkg::DB_DEPTH
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  logic [1:0]          sync_q;
  logic [DB_DEPTH-1:0] hist_q, hist_d;
  logic                level_q, level_d;
  logic                level_dly_q;
  logic                press_q;

  always_comb begin
    hist_d  = hist_q;
    level_d = level_q;
    if (tick_i) begin
      hist_d = {hist_q[DB_DEPTH-2:0], sync_q[1]};
      // Level follows the history only when it is unanimous; mixed histories hold.
      if (&hist_d) begin
        level_d = 1'b1;
      end else if (~|hist_d) begin
        level_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q      <= '0;
      hist_q      <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], btn_i};
      hist_q      <= hist_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/btn_ctrl.sv
// Button controller: debounces three pushbuttons and turns their presses into
// registered enable / speed / LED-reset controls for a downstream LED stage.
//
// Ports:
//   clk        system clock (rising edge)
//   rst_n      asynchronous active-low reset
//   btn_en     raw enable button  -> toggles en
//   btn_speed  raw speed button   -> toggles speed
//   btn_rst    raw reset button   -> one-cycle led_rst, clears en and speed
//   en, speed, led_rst  registered outputs (led_rst is 1 while rst_n is low)
//
// Build option: define BTN_CTRL_LONGPRESS_EN to clear en and speed once per
// hold when the debounced enable button stays high for LP_TICKS sample ticks.
module btn_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int unsigned SAMPLE_W = btn_ctrl_pkg::SAMPLE_W,
  parameter int unsigned DB_DEPTH = btn_ctrl_pkg::DB_DEPTH,
  parameter int unsigned LP_TICKS = btn_ctrl_pkg::LP_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_en,
  input  logic btn_speed,
  input  logic btn_rst,
  output logic en,
  output logic speed,
  output logic led_rst
);

  logic [SAMPLE_W-1:0] cnt_q;
  logic                tick;

  logic level_en, level_speed, level_rst;
  logic press_en, press_speed, press_rst;
  logic lp_hit;

  logic en_q, en_d;
  logic speed_q, speed_d;
  logic led_rst_q, led_rst_d;

  // Free-running prescaler; tick marks its all-ones cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + SAMPLE_W'(1);
    end
  end

  assign tick = &cnt_q;

  btn_debounce #(
    .DB_DEPTH (DB_DEPTH)
  ) u_db_en (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .tick_i  (tick),
    .btn_i   (btn_en),
    .level_o (level_en),
    .press_o (press_en)
  );

  btn_debounce #(
    .DB_DEPTH (DB_DEPTH)
  ) u_db_speed (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .tick_i  (tick),
    .btn_i   (btn_speed),
    .level_o (level_speed),
    .press_o (press_speed)
  );

  btn_debounce #(
    .DB_DEPTH (DB_DEPTH)
  ) u_db_rst (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .tick_i  (tick),
    .btn_i   (btn_rst),
    .level_o (level_rst),
    .press_o (press_rst)
  );

`ifdef BTN_CTRL_LONGPRESS_EN
  localparam int unsigned      LpW   = $clog2(LP_TICKS + 1);
  localparam logic [LpW-1:0]   LpMax = LpW'(LP_TICKS);

  logic [LpW-1:0] lp_cnt_q, lp_cnt_d;
  logic           lp_hit_q, lp_hit_d;

  always_comb begin
    lp_cnt_d = lp_cnt_q;
    if (!level_en) begin
      lp_cnt_d = '0;
    end else if (tick && (lp_cnt_q != LpMax)) begin
      lp_cnt_d = lp_cnt_q + LpW'(1);
    end
    // Fires only on the transition into saturation, so once per hold.
    lp_hit_d = (lp_cnt_d == LpMax) && (lp_cnt_q != LpMax);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lp_cnt_q <= '0;
      lp_hit_q <= 1'b0;
    end else begin
      lp_cnt_q <= lp_cnt_d;
      lp_hit_q <= lp_hit_d;
    end
  end

  assign lp_hit = lp_hit_q;

  logic unused_levels;
  assign unused_levels = ^{level_speed, level_rst};
`else
  assign lp_hit = 1'b0;

  // Hold length has no effect in this build; levels and LP_TICKS are not needed.
  logic unused_levels;
  assign unused_levels = ^{level_en, level_speed, level_rst, LP_TICKS[0]};
`endif

  always_comb begin
    en_d      = en_q;
    speed_d   = speed_q;
    led_rst_d = 1'b0;
    if (press_en) begin
      en_d = ~en_q;
    end
    if (press_speed) begin
      speed_d = (speed_q == SPEED_FAST) ? SPEED_SLOW : SPEED_FAST;
    end
    if (lp_hit) begin
      en_d    = 1'b0;
      speed_d = SPEED_SLOW;
    end
    // LED reset has the final word over any same-cycle toggle.
    if (press_rst) begin
      en_d      = 1'b0;
      speed_d   = SPEED_SLOW;
      led_rst_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      speed_q   <= SPEED_SLOW;
      led_rst_q <= 1'b1;
    end else begin
      en_q      <= en_d;
      speed_q   <= speed_d;
      led_rst_q <= led_rst_d;
    end
  end

  assign en      = en_q;
  assign speed   = speed_q;
  assign led_rst = led_rst_q;

endmodule

// File: tb/tb_btn_ctrl.sv
// Self-checking bench for btn_ctrl (SAMPLE_W=2, DB_DEPTH=4, LP_TICKS=8).
// Inputs change on falling edges and are held for whole tick periods (4 clk),
// so every held value is sampled exactly once per tick regardless of phase.
module tb_btn_ctrl;

  localparam int unsigned TickClk = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_en = 1'b0;
  logic btn_speed = 1'b0;
  logic btn_rst = 1'b0;
  logic en, speed, led_rst;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  // Output activity monitor (observation only, expectations come from the model).
  int unsigned en_toggles = 0;
  int unsigned sp_toggles = 0;
  int unsigned lr_cycles  = 0;
  logic        en_prev = 1'b0;
  logic        sp_prev = 1'b0;

  always #5 clk = ~clk;

  btn_ctrl #(
    .SAMPLE_W (2),
    .DB_DEPTH (4),
    .LP_TICKS (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_en    (btn_en),
    .btn_speed (btn_speed),
    .btn_rst   (btn_rst),
    .en        (en),
    .speed     (speed),
    .led_rst   (led_rst)
  );

  always @(negedge clk) begin
    en_prev <= en;
    sp_prev <= speed;
    if (rst_n) begin
      if (en !== en_prev)    en_toggles <= en_toggles + 1;
      if (speed !== sp_prev) sp_toggles <= sp_toggles + 1;
      if (led_rst === 1'b1)  lr_cycles  <= lr_cycles + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int unsigned n);
    repeat (n * TickClk) @(negedge clk);
  endtask

  task automatic set_btns(input logic [2:0] v);
    {btn_rst, btn_speed, btn_en} = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_btns(3'b000);
    repeat (3) @(negedge clk);
    check("rst_en", en, 0);
    check("rst_speed", speed, 0);
    check("rst_led_rst", led_rst, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_led_rst", led_rst, 0);
    check("rel_en", en, 0);
    check("rel_speed", speed, 0);
  endtask

  int unsigned s_en, s_sp, s_lr;
  logic [2:0]  prev, w, rise;
  logic        en_m, sp_m;
  int unsigned burst;

  initial begin
    // Reset behaviour.
    do_reset();

    // Two full presses of btn_en: 0->1 then 1->0, one toggle each.
    s_en = en_toggles;
    set_btns(3'b001);
    wait_ticks(6);
    check("en_press1", en, 1);
    check("en_press1_cnt", en_toggles - s_en, 1);
    set_btns(3'b000);
    wait_ticks(6);
    check("en_release", en, 1);
    set_btns(3'b001);
    wait_ticks(6);
    check("en_press2", en, 0);
    set_btns(3'b000);
    wait_ticks(6);

    // btn_speed alternating every tick never settles.
    s_sp = sp_toggles;
    for (int i = 0; i < 12; i++) begin
      btn_speed = (i % 2 == 0);
      wait_ticks(1);
    end
    btn_speed = 1'b0;
    wait_ticks(6);
    check("chatter_speed", speed, 0);
    check("chatter_cnt", sp_toggles - s_sp, 0);

    // en=1, speed=1, then btn_rst and btn_en together.
    set_btns(3'b011);
    wait_ticks(6);
    check("both_en", en, 1);
    check("both_speed", speed, 1);
    set_btns(3'b000);
    wait_ticks(6);
    s_lr = lr_cycles;
    set_btns(3'b101);
    wait_ticks(6);
    check("rstpress_lr_cycles", lr_cycles - s_lr, 1);
    check("rstpress_en", en, 0);
    check("rstpress_speed", speed, 0);
    check("rstpress_lr_now", led_rst, 0);
    set_btns(3'b000);
    wait_ticks(6);

    // Long hold of btn_en.
    s_en = en_toggles;
    set_btns(3'b001);
    wait_ticks(20);
`ifdef BTN_CTRL_LONGPRESS_EN
    check("hold_en", en, 0);
    check("hold_en_cnt", en_toggles - s_en, 2);
`else
    check("hold_en", en, 1);
    check("hold_en_cnt", en_toggles - s_en, 1);
`endif
    set_btns(3'b000);
    wait_ticks(6);

    // Reset in the middle of a btn_speed debounce.
    do_reset();
    s_sp = sp_toggles;
    btn_speed = 1'b1;
    wait_ticks(2);
    rst_n = 1'b0;
    btn_speed = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(6);
    check("midrst_speed", speed, 0);
    check("midrst_cnt", sp_toggles - s_sp, 0);
    btn_speed = 1'b1;
    wait_ticks(6);
    check("midrst_newpress", speed, 1);
    btn_speed = 1'b0;
    wait_ticks(6);

    // Randomised segments against a press-count model.
    do_reset();
    en_m = 1'b0;
    sp_m = 1'b0;
    prev = 3'b000;
    for (int seg = 0; seg < 40; seg++) begin
      w     = 3'($urandom_range(0, 7));
      burst = $urandom_range(0, 3);
`ifdef BTN_CTRL_LONGPRESS_EN
      // Keep every enable hold short of the long-press threshold.
      if (prev[0]) begin
        w[0]  = 1'b0;
        burst = 0;
      end
`endif
      s_lr = lr_cycles;
      for (int k = 0; k < int'(burst); k++) begin
        set_btns((k % 2 == 0) ? ~prev : prev);
        wait_ticks(1);
      end
      set_btns(w);
      wait_ticks(6);

      rise = w & ~prev;
      if (rise[2]) begin
        en_m = 1'b0;
        sp_m = 1'b0;
      end else begin
        en_m = en_m ^ rise[0];
        sp_m = sp_m ^ rise[1];
      end
      check($sformatf("rand%0d_en", seg), en, en_m);
      check($sformatf("rand%0d_speed", seg), speed, sp_m);
      check($sformatf("rand%0d_lr", seg), lr_cycles - s_lr, rise[2]);
      prev = w;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/btn_ctrl.md
BTN_CTRL -- requirements
Module: btn_ctrl

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, width of the sample-tick prescaler (one tick per 2^SAMPLE_W clk cycles).
REQ-002 SHALL have parameter DB_DEPTH, default 4, number of consecutive equal samples needed to change a debounced level.
REQ-003 SHALL have parameter LP_TICKS, default 64, sample ticks of btn_en hold that count as a long press (used only under REQ-021).
REQ-004 SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port btn_en  input  1  raw, asynchronous, bouncing enable pushbutton.
REQ-007 SHALL have port btn_speed  input  1  raw speed pushbutton.
REQ-008 SHALL have port btn_rst  input  1  raw LED-reset pushbutton.
REQ-009 SHALL have port en  output  1  registered enable level for the downstream LED stage.
REQ-010 SHALL have port speed  output  1  registered speed select (0 slow, 1 fast).
REQ-011 SHALL have port led_rst  output  1  registered active-high reset for the downstream LED stage.

Function
REQ-012 SHALL run a SAMPLE_W-bit free-running prescaler, incremented every clk and wrapping to 0, that asserts a one-cycle tick when it is all-ones.
REQ-013 SHALL pass each raw button through a 2-flop synchroniser before sampling.
REQ-014 SHALL shift each synchronised button into a DB_DEPTH-bit history on every tick; the debounced level becomes 1 when the history is all-ones, 0 when it is all-zeros, and otherwise holds.
REQ-015 SHALL produce a press pulse exactly one clk cycle long, registered, in the cycle after a debounced level rises 0->1; a falling edge produces no pulse.
REQ-016 SHALL toggle en on each btn_en press pulse and toggle speed on each btn_speed press pulse; simultaneous en and speed pulses SHALL both take effect in the same cycle.
REQ-017 SHALL, on a btn_rst press pulse, drive led_rst=1 for exactly one cycle and clear en and speed to 0 in that cycle, overriding any same-cycle toggle.
REQ-018 SHALL give a button held continuously high a first press pulse no later than DB_DEPTH ticks plus 4 clk cycles after the press, and exactly one pulse per press regardless of hold length.
REQ-019 SHALL leave en, speed and led_rst unchanged by input activity that alternates faster than DB_DEPTH ticks.

Reset
REQ-020 SHALL, while rst_n=0, asynchronously force prescaler=0, all synchronisers and histories=0, debounced levels=0, en=0, speed=0 and led_rst=1; led_rst SHALL return to 0 on the first clk edge after release, and no press pulse SHALL result from the reset itself, including a reset applied mid-debounce.

Configuration
REQ-021 SHALL, with BTN_CTRL_LONGPRESS_EN defined, count ticks while debounced btn_en is high (counter saturating at LP_TICKS, cleared when it is low); on reaching LP_TICKS it SHALL clear en and speed to 0 once per hold, after the normal toggle from REQ-016.
REQ-022 SHALL, without BTN_CTRL_LONGPRESS_EN, contain no long-press counter, so that hold length has no effect beyond REQ-018.

Structure
REQ-023 SHALL place the default constants (SAMPLE_W, DB_DEPTH, LP_TICKS) and the speed encoding constants SPEED_SLOW=0 and SPEED_FAST=1 in the shared package btn_ctrl_pkg.
REQ-024 SHALL implement the synchroniser, history, debounced level and press pulse of REQ-013 to REQ-015 as a sub-module btn_debounce, instantiated three times and sharing one prescaler tick.

Verification (bench uses SAMPLE_W=2, DB_DEPTH=4, LP_TICKS=8)
REQ-025 SHALL cover: rst_n=0 -> en=0, speed=0, led_rst=1; release rst_n -> led_rst=0 after one clk, en and speed stay 0.
REQ-026 SHALL cover: btn_en held 1 for 6 ticks -> exactly one toggle, en 0->1; release, then press again for 6 ticks -> en 1->0.
REQ-027 SHALL cover: btn_speed inverted every tick for 12 ticks -> speed stays 0 and no pulse occurs.
REQ-028 SHALL cover: en=1, speed=1, then btn_rst and btn_en pressed in the same clk -> led_rst high for one cycle, then en=0 and speed=0.
REQ-029 SHALL cover: btn_en held 20 ticks -> with BTN_CTRL_LONGPRESS_EN, en goes 0->1 then back to 0 at hold tick 8; without the macro, en stays 1.
REQ-030 SHALL cover: rst_n pulsed low after 2 of the 4 debounce samples of a btn_speed press -> speed=0 and no pulse after release until a full new press.
